// File: rtl/pid_pwm_pkg.sv
// Shared constants for the PID-to-PWM output stage: dead-time FSM state encoding,
// default timing parameters and the uk0 scaling helper.
package pid_pwm_pkg;

  localparam int unsigned UkW       = 15;
  localparam int unsigned DefCntW   = 10;
  localparam int unsigned DefPeriod = 1000;
  localparam int unsigned DefDead   = 4;
  localparam int unsigned DefShift  = 4;

  typedef logic [2:0] pwm_state_t;

  localparam pwm_state_t StIdle = 3'd0;
  localparam pwm_state_t StLon  = 3'd1;
  localparam pwm_state_t StDtH  = 3'd2;
  localparam pwm_state_t StHon  = 3'd3;
  localparam pwm_state_t StDtL  = 3'd4;

  // Sign-preserving scale-down of the PID output before it is clamped to a duty value.
  function automatic int uk_shift(input logic signed [UkW-1:0] uk, input int unsigned shift);
    int v;
    v = int'(uk);
    return v >>> shift;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate driver: turns the raw comparator level into pwm_h/pwm_l with
// a guaranteed all-off interval of DEAD cycles before either gate switches on.
module pwm_deadtime
  import pid_pwm_pkg::*;
#(
  parameter int unsigned DEAD = DefDead
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic pwm_h,
  output logic pwm_l
);

  localparam logic [3:0] DeadLd = 4'(DEAD);

  pwm_state_t state_q, state_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic       pwm_h_q, pwm_l_q;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (!en) begin
      state_d = StIdle;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        // Leaving idle always passes through a full low-side dead interval.
        StIdle: begin
          state_d = StDtL;
          dcnt_d  = DeadLd;
        end
        StLon: begin
          if (raw) begin
            state_d = StDtH;
            dcnt_d  = DeadLd;
          end
        end
        StHon: begin
          if (!raw) begin
            state_d = StDtL;
            dcnt_d  = DeadLd;
          end
        end
        StDtH: begin
          if (!raw) begin
            state_d = StDtL;
            dcnt_d  = DeadLd;
          end else if (dcnt_q == 4'd1) begin
            state_d = StHon;
          end else begin
            dcnt_d = dcnt_q - 4'd1;
          end
        end
        StDtL: begin
          if (raw) begin
            state_d = StDtH;
            dcnt_d  = DeadLd;
          end else if (dcnt_q == 4'd1) begin
            state_d = StLon;
          end else begin
            dcnt_d = dcnt_q - 4'd1;
          end
        end
        default: begin
          state_d = StIdle;
          dcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dcnt_q  <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pwm_h_q <= (state_d == StHon);
      pwm_l_q <= (state_d == StLon);
    end
  end

  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;

endmodule

// File: rtl/pid_pwm_driver.sv
// PID output to PWM: clamps uk0 into a shadow duty register, runs the period counter
// and feeds the compare level to the dead-time gate driver.
module pid_pwm_driver
  import pid_pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned PERIOD = DefPeriod,
  parameter int unsigned DEAD   = DefDead,
  parameter int unsigned SHIFT  = DefShift
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic signed [UkW-1:0] uk0,
  input  logic                  uk_valid,
  output logic                  pwm_h,
  output logic                  pwm_l,
  output logic [CNT_W-1:0]      duty,
  output logic                  period_start,
  output logic                  sat_hi,
  output logic                  sat_lo
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DutyMax = CNT_W'(PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] clamp_val;
  logic             period_start_q;
  logic             sat_hi_q, sat_lo_q;
  logic             clamp_hi, clamp_lo;
  logic             wrap;
  logic             raw;
  int               scaled;

  always_comb begin
    scaled    = uk_shift(uk0, SHIFT);
    clamp_lo  = (scaled < 0);
    clamp_hi  = (scaled > int'(PERIOD));
    clamp_val = clamp_lo ? '0 : (clamp_hi ? DutyMax : CNT_W'(scaled));

    wrap      = en && (cnt_q == CntLast);
    cnt_d     = (!en || wrap) ? '0 : cnt_q + 1'b1;
    pending_d = uk_valid ? clamp_val : pending_q;
    // A strobe landing on the wrap cycle goes straight into the next period.
    duty_d    = wrap ? pending_d : duty_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      pending_q      <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
      sat_hi_q       <= 1'b0;
      sat_lo_q       <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      duty_q         <= duty_d;
      period_start_q <= en && (cnt_q == '0);
      if (uk_valid) begin
        sat_hi_q <= clamp_hi;
        sat_lo_q <= clamp_lo;
      end
    end
  end

  assign raw = (cnt_q < duty_q);

  pwm_deadtime #(
    .DEAD(DEAD)
  ) u_deadtime (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .raw  (raw),
    .pwm_h(pwm_h),
    .pwm_l(pwm_l)
  );

  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign sat_hi       = sat_hi_q;
  assign sat_lo       = sat_lo_q;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Bench for pid_pwm_driver: directed scenarios plus random traffic, scored cycle by
// cycle against a reference built from period arithmetic and gate history windows.
module tb_pid_pwm_driver;

  localparam int unsigned CntW   = 10;
  localparam int unsigned Period = 100;
  localparam int unsigned Dead   = 3;
  localparam int unsigned ShiftA = 0;
  localparam int unsigned ShiftB = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               uk_valid;
  logic signed [14:0] uk0;

  logic            pwm_h, pwm_l, period_start, sat_hi, sat_lo;
  logic [CntW-1:0] duty;
  logic            pwm_h_b, pwm_l_b, period_start_b, sat_hi_b, sat_lo_b;
  logic [CntW-1:0] duty_b;

  always #5 clk = ~clk;

  pid_pwm_driver #(
    .CNT_W (CntW),
    .PERIOD(Period),
    .DEAD  (Dead),
    .SHIFT (ShiftA)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .uk0         (uk0),
    .uk_valid    (uk_valid),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .duty        (duty),
    .period_start(period_start),
    .sat_hi      (sat_hi),
    .sat_lo      (sat_lo)
  );

  // Second instance exercises the scaling shift on the same stimulus.
  pid_pwm_driver #(
    .CNT_W (CntW),
    .PERIOD(Period),
    .DEAD  (Dead),
    .SHIFT (ShiftB)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .uk0         (uk0),
    .uk_valid    (uk_valid),
    .pwm_h       (pwm_h_b),
    .pwm_l       (pwm_l_b),
    .duty        (duty_b),
    .period_start(period_start_b),
    .sat_hi      (sat_hi_b),
    .sat_lo      (sat_lo_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  int m_cnt;
  int m_pend[2];
  int m_duty[2];
  bit m_shi[2];
  bit m_slo[2];
  bit m_ps;
  bit exp_h, exp_l;
  bit eh[$];  // eh[0] = gate-enable of the previous cycle, eh[1] the one before...
  bit rh[$];  // same for the compare level cnt < duty

  function automatic int floor_shift(input int u, input int sh);
    int d;
    d = 1 << sh;
    if (u >= 0) return u / d;
    return -((-u + d - 1) / d);
  endfunction

  task automatic tick();
    bit e_now, r_now, wrap;
    int v;
    int sh;
    @(posedge clk);
    e_now = en && !rst;
    r_now = (m_cnt < m_duty[0]);
    eh.push_front(e_now);
    rh.push_front(r_now);
    void'(eh.pop_back());
    void'(rh.pop_back());

    // High side: DEAD+1 enabled cycles of raw=1, entered from a non-idle state.
    exp_h = eh[Dead+1];
    for (int k = 0; k <= Dead; k++) exp_h = exp_h && eh[k] && rh[k];
    // Low side: DEAD cycles of raw=0 after a raw=0 cycle, or right after leaving idle.
    exp_l = !eh[Dead+1] || !rh[Dead];
    for (int k = 0; k <= Dead; k++) exp_l = exp_l && eh[k];
    for (int k = 0; k < Dead; k++) exp_l = exp_l && !rh[k];

    if (rst) begin
      m_cnt = 0;
      m_ps  = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 0;
        m_duty[i] = 0;
        m_shi[i]  = 1'b0;
        m_slo[i]  = 1'b0;
      end
    end else begin
      wrap = en && (m_cnt == Period - 1);
      m_ps = en && (m_cnt == 0);
      for (int i = 0; i < 2; i++) begin
        sh = (i == 0) ? ShiftA : ShiftB;
        v  = floor_shift(int'(uk0), sh);
        if (uk_valid) begin
          m_slo[i]  = (v < 0);
          m_shi[i]  = (v > int'(Period));
          m_pend[i] = (v < 0) ? 0 : ((v > int'(Period)) ? Period : v);
        end
        if (wrap) m_duty[i] = m_pend[i];
      end
      m_cnt = (!en || wrap) ? 0 : m_cnt + 1;
    end

    #1;
    check_eq("pwm_h", pwm_h, exp_h);
    check_eq("pwm_l", pwm_l, exp_l);
    check_eq("overlap", pwm_h & pwm_l, 0);
    check_eq("period_start", period_start, m_ps);
    check_eq("duty", duty, m_duty[0]);
    check_eq("sat_hi", sat_hi, m_shi[0]);
    check_eq("sat_lo", sat_lo, m_slo[0]);
    check_eq("duty_b", duty_b, m_duty[1]);
    check_eq("sat_hi_b", sat_hi_b, m_shi[1]);
    check_eq("sat_lo_b", sat_lo_b, m_slo[1]);
    check_eq("period_start_b", period_start_b, m_ps);
    check_eq("overlap_b", pwm_h_b & pwm_l_b, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int val);
    uk0      = 15'(val);
    uk_valid = 1'b1;
    tick();
    uk_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i <= Period && m_cnt != c; i++) tick();
    check_eq("wait_cnt_reached", m_cnt, c);
  endtask

  task automatic gate_widths(input int exp_hc, input int exp_lc);
    int hc, lc;
    hc = 0;
    lc = 0;
    for (int i = 0; i < Period; i++) begin
      tick();
      hc += int'(pwm_h);
      lc += int'(pwm_l);
    end
    check_eq("h_width", hc, exp_hc);
    check_eq("l_width", lc, exp_lc);
  endtask

  initial begin
    int r, tmp;
    rst      = 1'b1;
    en       = 1'b0;
    uk_valid = 1'b0;
    uk0      = '0;
    for (int k = 0; k < Dead + 2; k++) begin
      eh.push_back(1'b0);
      rh.push_back(1'b0);
    end
    run(3);
    check_eq("reset_duty", duty, 0);
    rst = 1'b0;

    // Nominal duty: steady periods give 40-DEAD high and 60-DEAD low.
    en = 1'b1;
    strobe(40);
    run(250);
    gate_widths(40 - Dead, 60 - Dead);

    // Saturation both ways.
    strobe(-5);
    run(250);
    check_eq("sat_lo_dir", sat_lo, 1);
    gate_widths(0, Period);
    strobe(300);
    run(250);
    check_eq("sat_hi_dir", sat_hi, 1);
    check_eq("duty_full", duty, Period);
    gate_widths(Period, 0);

    // Strobe exactly on the wrap cycle bypasses the shadow register.
    strobe(10);
    run(250);
    wait_cnt(Period - 1);
    strobe(70);
    check_eq("bypass", duty, 70);
    wait_cnt(50);
    strobe(30);
    check_eq("mid_hold", duty, 70);
    wait_cnt(Period - 1);
    tick();
    check_eq("mid_load", duty, 30);

    // Pulse narrower than the dead time never reaches the high side.
    strobe(2);
    run(250);
    gate_widths(0, Period - 2 - Dead);

    // Enable drop in the middle of the high phase, then restart.
    strobe(50);
    run(250);
    wait_cnt(20);
    en = 1'b0;
    tick();
    check_eq("en_drop_h", pwm_h, 0);
    run(5);
    en = 1'b1;
    run(20);

    // Synchronous reset mid-period clears duty until a new strobe and wrap.
    wait_cnt(30);
    rst = 1'b1;
    tick();
    check_eq("rst_pwm_h", pwm_h, 0);
    rst = 1'b0;
    run(150);
    check_eq("duty_after_rst", duty, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) en = !en;
      uk_valid = ($urandom_range(0, 29) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 7) tmp = int'($urandom_range(0, 1000)) - 100;
      else if (r == 7) tmp = int'($urandom_range(0, 32767)) - 16384;
      else tmp = int'($urandom_range(0, 8));
      uk0 = tmp[14:0];
      tick();
    end
    rst      = 1'b0;
    uk_valid = 1'b0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
